// File: rtl/fm_pkg.sv
// Shared types and constants for the frequency/period meter.
package fm_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} fm_state_t;
  localparam int CLK_HZ = 50_000_000;
endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous pin into clk and emits a registered
// one-cycle pulse on each rising edge (SYNC_STAGES+1 cycles of latency).
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      last_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end
endmodule

// File: rtl/freq_meter.sv
// Measures rising edges per gate window (frequency) and clk cycles between
// consecutive rising edges (period) of an asynchronous input pin.
module freq_meter
  import fm_pkg::*;
#(
  parameter int GATE_CYCLES    = CLK_HZ,
  parameter int TIMEOUT_CYCLES = CLK_HZ,
  parameter int CNT_W          = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic             edge_seen,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             stalled
);
  // Gate counter is sized from the window length, independent of CNT_W.
  localparam int                GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);

  fm_state_t         state, state_nxt;
  logic              rise, gate_end, timeout_hit;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt, period_cnt;
  logic              ovf_pend;

  always_ff @(posedge clk) begin
    a_cfg: assert (SYNC_STAGES >= 2 && GATE_CYCLES >= 2 &&
                   64'(TIMEOUT_CYCLES) < (64'd1 << CNT_W))
      else $error("freq_meter: illegal parameter combination");
  end

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  assign edge_seen   = rise && (state != IDLE);
  assign gate_end    = (gate_cnt == GATE_LAST);
  assign timeout_hit = (state == RUN) && !rise && (period_cnt == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = RUN;
        RUN:     if (timeout_hit) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      period_cnt   <= '0;
      ovf_pend     <= 1'b0;
      freq_out     <= '0;
      freq_valid   <= 1'b0;
      freq_ovf     <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      freq_valid   <= 1'b0;
      period_valid <= 1'b0;
      if (state != IDLE) begin
        gate_cnt <= gate_end ? '0 : gate_cnt + 1'b1;
        // An edge landing on the last gate cycle belongs to the closing window.
        if (gate_end) begin
          freq_out   <= (rise && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;
          freq_ovf   <= ovf_pend | (rise && edge_cnt == CNT_MAX);
          freq_valid <= 1'b1;
          edge_cnt   <= '0;
          ovf_pend   <= 1'b0;
        end else if (rise) begin
          if (edge_cnt == CNT_MAX) ovf_pend <= 1'b1;
          else                     edge_cnt <= edge_cnt + 1'b1;
        end

        if (rise) begin
          period_cnt <= CNT_W'(1);
          if (state == RUN) begin
            period_out   <= period_cnt;
            period_valid <= 1'b1;
            stalled      <= 1'b0;
          end
        end else if (timeout_hit) begin
          period_out   <= '0;
          period_valid <= 1'b1;
          stalled      <= 1'b1;
          period_cnt   <= '0;
        end else if (state == RUN) begin
          period_cnt <= period_cnt + 1'b1;
        end
      end
    end
  end
endmodule
